fifo_uart_tx: RTL and testbench

- Read-side consumer of the 8-bit show-ahead FIFO: drains queued bytes and serialises each as one UART 8N1 frame on `tx`.
- Sits between the FIFO's pop port and the board TX pin.
- Owns the pop handshake: pops exactly one byte per frame, and only when the FIFO is non-empty.
- Contains its own bit-period counter, so no external baud tick is needed.

---
 rtl/fifo_uart_tx.sv | 86 ++++++++
 tb/tb_fifo_uart_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a show-ahead FIFO, popping one byte per frame.
// Contains its own bit-period counter; tx idles high.
module fifo_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       empty,
  input  logic [7:0] pop_data,
  output logic       pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // State register plus the per-bit datapath that moves with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_busy <= (state_nxt != IDLE);
      tx_done <= (state == STOP) && bit_end;

      if ((state == IDLE) || (state_nxt != state) || bit_end)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (state != DATA)
        bit_idx <= '0;
      else if (bit_end)
        bit_idx <= bit_idx + 3'd1;

      if (pop)
        shift_reg <= pop_data;
      else if ((state == DATA) && bit_end)
        shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pop) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pop is Mealy on tx_en/empty and held off while reset is asserted
  always_comb begin
    pop = rst && (state == IDLE) && tx_en && !empty;
    tx  = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       empty;
  logic [7:0] pop_data;
  logic       pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  fifo_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_en    (tx_en),
    .empty    (empty),
    .pop_data (pop_data),
    .pop      (pop),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in the pop cycle; checks the 160-clock frame and the tx_done cycle after it.
  task automatic send_frame(input logic [7:0] b, input logic [7:0] nxt,
                            input logic nxt_empty, input int drop_at);
    logic want_bit;
    int   k;
    for (int c = 1; c <= 160; c++) begin
      cyc();
      if (c == 1) begin
        pop_data = nxt;
        empty    = nxt_empty;
      end
      if (c == drop_at) tx_en = 1'b0;
      #1;
      k = (c - 1) / 16;
      if (k == 0)      want_bit = 1'b0;
      else if (k == 9) want_bit = 1'b1;
      else             want_bit = b[k-1];
      check($sformatf("tx_%02h_c%0d", b, c), {7'd0, tx}, {7'd0, want_bit});
      check($sformatf("busy_%02h_c%0d", b, c), {7'd0, tx_busy}, 8'd1);
      check($sformatf("pop_%02h_c%0d", b, c), {7'd0, pop}, 8'd0);
      check($sformatf("done_%02h_c%0d", b, c), {7'd0, tx_done}, 8'd0);
    end
    cyc();
    #1;
    check($sformatf("done_pulse_%02h", b), {7'd0, tx_done}, 8'd1);
    check($sformatf("gap_busy_%02h", b), {7'd0, tx_busy}, 8'd0);
    check($sformatf("gap_tx_%02h", b), {7'd0, tx}, 8'd1);
  endtask

  initial begin
    rst      = 1'b1;
    tx_en    = 1'b1;
    empty    = 1'b0;
    pop_data = 8'hA5;
    #1 rst = 1'b0;

    // 1: reset holds everything quiet even with data available
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rst_tx", {7'd0, tx}, 8'd1);
      check("rst_pop", {7'd0, pop}, 8'd0);
      check("rst_busy", {7'd0, tx_busy}, 8'd0);
      check("rst_done", {7'd0, tx_done}, 8'd0);
    end
    rst = 1'b1;
    #1;
    check("release_pop", {7'd0, pop}, 8'd1);

    // 2: single byte 0xA5, FIFO empties afterwards
    send_frame(8'hA5, 8'hA5, 1'b1, -1);
    check("a5_no_repop", {7'd0, pop}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("a5_idle_pop", {7'd0, pop}, 8'd0);
      check("a5_idle_done", {7'd0, tx_done}, 8'd0);
      check("a5_idle_tx", {7'd0, tx}, 8'd1);
    end

    // 3: three queued bytes back to back, one idle clock between frames
    pop_data = 8'h00;
    empty    = 1'b0;
    #1;
    check("q0_pop", {7'd0, pop}, 8'd1);
    send_frame(8'h00, 8'hFF, 1'b0, -1);
    check("q1_pop", {7'd0, pop}, 8'd1);
    send_frame(8'hFF, 8'h55, 1'b0, -1);
    check("q2_pop", {7'd0, pop}, 8'd1);
    send_frame(8'h55, 8'h00, 1'b1, -1);
    check("q_end_pop", {7'd0, pop}, 8'd0);
    cyc();
    check("q_end_busy", {7'd0, tx_busy}, 8'd0);

    // 4: tx_en gating, then drop tx_en during data bit 3
    tx_en    = 1'b0;
    empty    = 1'b0;
    pop_data = 8'h3C;
    for (int i = 0; i < 500; i++) begin
      cyc();
      check("gate_pop", {7'd0, pop}, 8'd0);
      check("gate_tx", {7'd0, tx}, 8'd1);
    end
    tx_en = 1'b1;
    #1;
    check("en_rise_pop", {7'd0, pop}, 8'd1);
    send_frame(8'h3C, 8'h3C, 1'b0, 70);
    check("en_drop_pop", {7'd0, pop}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("en_off_pop", {7'd0, pop}, 8'd0);
      check("en_off_busy", {7'd0, tx_busy}, 8'd0);
    end

    // 5: asynchronous reset during data bit 4 of 0xC3 (bit 4 = 0)
    pop_data = 8'hC3;
    tx_en    = 1'b1;
    #1;
    check("c3_pop", {7'd0, pop}, 8'd1);
    for (int c = 1; c <= 85; c++) cyc();
    check("c3_bit4_tx", {7'd0, tx}, 8'd0);
    check("c3_bit4_busy", {7'd0, tx_busy}, 8'd1);
    empty = 1'b1;
    rst   = 1'b0;
    #1;
    check("arst_tx", {7'd0, tx}, 8'd1);
    check("arst_busy", {7'd0, tx_busy}, 8'd0);
    check("arst_pop", {7'd0, pop}, 8'd0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("post_rst_pop", {7'd0, pop}, 8'd0);
      check("post_rst_tx", {7'd0, tx}, 8'd1);
      check("post_rst_busy", {7'd0, tx_busy}, 8'd0);
    end

    // 6: starvation, then a one-cycle non-empty glitch
    for (int i = 0; i < 1000; i++) begin
      cyc();
      check("starve_pop", {7'd0, pop}, 8'd0);
      check("starve_tx", {7'd0, tx}, 8'd1);
    end
    pop_data = 8'h96;
    empty    = 1'b0;
    #1;
    check("glitch_pop", {7'd0, pop}, 8'd1);
    send_frame(8'h96, 8'h96, 1'b1, -1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("glitch_after_pop", {7'd0, pop}, 8'd0);
      check("glitch_after_busy", {7'd0, tx_busy}, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
